// File: rtl/ram_sdp_param_if.sv
// Bus bundle for the simple-dual-port RAM: write port, read port and status.
// Pure wiring, no latency of its own.
// No backpressure: the RAM accepts one read and one write every cycle once initialised.
interface ram_sdp_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic                      we;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [ADDR_WIDTH-1:0]     waddr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      re;
    logic [ADDR_WIDTH-1:0]     raddr;
    logic [DATA_WIDTH-1:0]     q;
    logic                      q_valid;
    logic                      init_busy;

    // Requester side: drives write/read requests, observes read data and init status.
    modport master (
        output we, be, waddr, wdata, re, raddr,
        input  q, q_valid, init_busy
    );

    // Memory side: consumes requests, returns read data and init status.
    modport slave (
        input  we, be, waddr, wdata, re, raddr,
        output q, q_valid, init_busy
    );
endinterface

// File: rtl/ram_sdp_param.sv
// Parametrised simple-dual-port RAM with byte enables, read-valid strobe and a post-reset init sequencer.
// Read latency 1 cycle (2 with OUT_REG=1); writes land on the sampling edge.
// No backpressure in RUN; requests are ignored while init_busy is high (DEPTH cycles after reset).
module ram_sdp_param #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    RDW_NEW    = 0,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst,
    ram_sdp_param_if.slave bus
);
    localparam int                    NB        = DATA_WIDTH / 8;
    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_init_cnt;
    logic                    w_in_init;

    logic                    w_wr_en;
    logic [NB-1:0]           w_wr_be;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic [DATA_WIDTH-1:0]   w_wr_dat;

    logic                    w_rd_en;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_rd_dat;
    logic                    r_rd_vld;

    // State register and init address counter; the counter wraps to 0 as INIT completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    // Next state and write-port ownership: the sequencer owns the array during INIT.
    always_comb begin
        w_state_nxt = r_state;
        w_in_init   = (r_state == ST_INIT);
        w_wr_en     = bus.we;
        w_wr_be     = bus.be;
        w_wr_addr   = bus.waddr;
        w_wr_dat    = bus.wdata;
        w_rd_en     = bus.re;
        if (w_in_init) begin
            w_wr_en   = 1'b1;
            w_wr_be   = '1;
            w_wr_addr = r_init_cnt;
            w_wr_dat  = INIT_VALUE;
            w_rd_en   = 1'b0;
            if (r_init_cnt == LAST_ADDR) begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    assign bus.init_busy = w_in_init;

    // Byte-granular array write; contents are never reset, only overwritten by the sequencer.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (w_wr_en && w_wr_be[b]) begin
                r_mem[w_wr_addr][8*b +: 8] <= w_wr_dat[8*b +: 8];
            end
        end
    end

    // Read word selection: optional per-byte forwarding of same-address write data.
    always_comb begin
        w_rd_word = r_mem[bus.raddr];
        if ((RDW_NEW != 0) && bus.we && (bus.waddr == bus.raddr)) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.be[b]) begin
                    w_rd_word[8*b +: 8] = bus.wdata[8*b +: 8];
                end
            end
        end
    end

    // First read stage: data holds between reads, valid is a one-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_dat <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_en;
            if (w_rd_en) begin
                r_rd_dat <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_q;
            logic                  r_q_vld;

            // Second stage loads only on a valid first-stage read so q holds between reads.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q     <= '0;
                    r_q_vld <= 1'b0;
                end else begin
                    r_q_vld <= r_rd_vld;
                    if (r_rd_vld) begin
                        r_q <= r_rd_dat;
                    end
                end
            end

            assign bus.q       = r_q;
            assign bus.q_valid = r_q_vld;
        end else begin : g_no_out_reg
            assign bus.q       = r_rd_dat;
            assign bus.q_valid = r_rd_vld;
        end
    endgenerate
endmodule
